// File: rtl/ats21_pkg.sv
// Shared types and helpers for the ATS21 alarm collector.
package ats21_pkg;

    localparam int unsigned NUM_ALARMS = 24;
    localparam int unsigned ALARM_ID_W = 5;
    localparam int unsigned TS_WIDTH   = 16;

    // One queued alarm event: which alarm fired and when it was queued.
    typedef struct packed {
        logic [ALARM_ID_W-1:0] id;
        logic [TS_WIDTH-1:0]   ts;
    } alarm_evt_t;

    typedef struct packed {
        logic                  found;
        logic [ALARM_ID_W-1:0] id;
    } prio_t;

    // Lowest set bit wins; scanning downwards lets the lowest index overwrite.
    function automatic prio_t prio_lowest(input logic [NUM_ALARMS-1:0] vec);
        prio_t res;
        res = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res.found = 1'b1;
                res.id    = ALARM_ID_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ats21_alarm_collector_if.sv
// Host-side event port: valid/ready handshake carrying {id, ts} of the FIFO head.
interface ats21_alarm_collector_if #(
    parameter int unsigned TS_WIDTH = 16
);
    logic                evt_valid;
    logic                evt_ready;
    logic [4:0]          evt_id;
    logic [TS_WIDTH-1:0] evt_ts;

    // Collector side produces records.
    modport master (
        output evt_valid,
        output evt_id,
        output evt_ts,
        input  evt_ready
    );

    // Host side consumes records.
    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_ts,
        output evt_ready
    );
endinterface

// File: rtl/ats21_evt_fifo.sv
// Show-ahead event FIFO; the head is held in a register so it keeps its last
// value when the FIFO drains and reads 0 after reset.
module ats21_evt_fifo
    import ats21_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  alarm_evt_t      din,
    output alarm_evt_t      dout,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    alarm_evt_t      mem_q [DEPTH];
    logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    alarm_evt_t      head_q, head_d;
    logic            do_push, do_pop;

    // Pointer/count update and selection of the next head record.
    always_comb begin
        do_pop  = pop & (cnt_q != '0);
        do_push = push & ((cnt_q != FullCnt) | do_pop);
        wr_d    = wr_q + PtrW'(do_push);
        rd_d    = rd_q + PtrW'(do_pop);
        cnt_d   = cnt_q + CntW'(do_push) - CntW'(do_pop);
        head_d  = head_q;
        if (cnt_d != '0) begin
            // The incoming record becomes head when nothing older survives this edge.
            if ((cnt_q == '0) || ((cnt_q == CntW'(1)) && do_pop)) begin
                head_d = din;
            end else begin
                head_d = mem_q[rd_d];
            end
        end
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

    assign dout  = head_q;
    assign full  = (cnt_q == FullCnt);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/ats21_alarm_collector.sv
// Collects ATS21 alarm rising edges into a timestamped event FIFO with irq and
// a saturating count of events coalesced into an already-pending alarm.
// NUM_ALARMS and TS_WIDTH must match the ats21_pkg record layout.
module ats21_alarm_collector
    import ats21_pkg::*;
#(
    parameter int unsigned NUM_ALARMS = ats21_pkg::NUM_ALARMS,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TS_WIDTH   = ats21_pkg::TS_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_ALARMS-1:0]   alarm_in,
    input  logic [NUM_ALARMS-1:0]   alarm_mask,
    ats21_alarm_collector_if.master evt,
    output logic                    irq,
    output logic [NUM_ALARMS-1:0]   pending,
    output logic [7:0]              ovf_count,
    input  logic                    clr_ovf
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_ALARMS-1:0] prev_q, prev_d, pending_q, pending_d;
    logic [NUM_ALARMS-1:0] rise, push_onehot, coalesce;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [7:0]            ovf_q, ovf_d, n_coal;
    logic [8:0]            ovf_sum;
    logic                  irq_q, irq_d;
    logic [CntW-1:0]       count, count_nxt;
    logic                  push, pop, full, empty;
    prio_t                 sel;
    alarm_evt_t            din, dout;

    // Edge detect, arbitration and push/pop decisions.
    always_comb begin
        rise        = alarm_in & ~prev_q & alarm_mask;
        sel         = prio_lowest(pending_q);
        pop         = ~empty & evt.evt_ready;
        push        = sel.found & (~full | pop);
        push_onehot = '0;
        if (push) begin
            push_onehot[sel.id] = 1'b1;
        end
        din.id = sel.id;
        din.ts = ts_q;
    end

    // Next-state for pending, overflow counter, timestamp and irq.
    always_comb begin
        // A rise on a bit being pushed this cycle re-arms it rather than coalescing.
        coalesce = rise & pending_q & ~push_onehot;
        n_coal   = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            n_coal = n_coal + {7'd0, coalesce[i]};
        end
        pending_d = (pending_q & ~push_onehot) | rise;
        ovf_sum   = (clr_ovf ? 9'd0 : {1'b0, ovf_q}) + {1'b0, n_coal};
        ovf_d     = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
        ts_d      = ts_q + TS_WIDTH'(1);
        prev_d    = alarm_in;
        count_nxt = count + CntW'(push) - CntW'(pop);
        irq_d     = (count_nxt != '0);
    end

    // State registers; prev tracks alarm_in even in reset so held bits don't fire.
    always_ff @(posedge clk) begin
        prev_q <= prev_d;
        if (reset) begin
            pending_q <= '0;
            ovf_q     <= '0;
            ts_q      <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            ts_q      <= ts_d;
            irq_q     <= irq_d;
        end
    end

    ats21_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign evt.evt_valid = ~empty;
    assign evt.evt_id    = dout.id;
    assign evt.evt_ts    = dout.ts;
    assign irq           = irq_q;
    assign pending       = pending_q;
    assign ovf_count     = ovf_q;

endmodule

// File: tb/tb_ats21_alarm_collector.sv
// Self-checking bench for ats21_alarm_collector: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_ats21_alarm_collector;

    localparam int unsigned NA    = 24;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TSW   = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NA-1:0] alarm_in = '0;
    logic [NA-1:0] alarm_mask = '1;
    logic          clr_ovf = 1'b0;
    logic          irq;
    logic [NA-1:0] pending;
    logic [7:0]    ovf_count;

    ats21_alarm_collector_if #(.TS_WIDTH(TSW)) evt_if ();

    ats21_alarm_collector #(
        .NUM_ALARMS (NA),
        .FIFO_DEPTH (DEPTH),
        .TS_WIDTH   (TSW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alarm_in   (alarm_in),
        .alarm_mask (alarm_mask),
        .evt        (evt_if),
        .irq        (irq),
        .pending    (pending),
        .ovf_count  (ovf_count),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    typedef struct {
        int id;
        int ts;
    } rec_t;
    rec_t          m_q[$];
    bit [NA-1:0]   m_prev;
    bit [NA-1:0]   m_pend;
    int            m_ts;
    int            m_ovf;
    int            m_hid;
    int            m_hts;
    bit            m_irq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sees.
    task automatic model_edge();
        int          sel;
        bit          do_pop;
        bit          do_push;
        int          n;
        bit [NA-1:0] rises;
        if (reset) begin
            m_prev = alarm_in;
            m_pend = '0;
            m_q.delete();
            m_ts   = 0;
            m_ovf  = 0;
            m_hid  = 0;
            m_hts  = 0;
            m_irq  = 0;
        end else begin
            do_pop = (m_q.size() != 0) && evt_if.evt_ready;
            sel = -1;
            for (int i = 0; i < NA; i++) if (m_pend[i] && sel < 0) sel = i;
            do_push = (sel >= 0) && ((m_q.size() < DEPTH) || do_pop);
            n = 0;
            rises = '0;
            for (int j = 0; j < NA; j++) begin
                if (alarm_in[j] && !m_prev[j] && alarm_mask[j]) begin
                    rises[j] = 1'b1;
                    if (m_pend[j] && !(do_push && j == sel)) n++;
                end
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back('{id: sel, ts: m_ts});
                m_pend[sel] = 1'b0;
            end
            m_pend = m_pend | rises;
            if (clr_ovf) m_ovf = 0;
            m_ovf = (m_ovf + n > 255) ? 255 : m_ovf + n;
            m_ts   = (m_ts + 1) % 65536;
            m_prev = alarm_in;
            m_irq  = (m_q.size() != 0);
            if (m_q.size() != 0) begin
                m_hid = m_q[0].id;
                m_hts = m_q[0].ts;
            end
        end
    endtask

    task automatic check_model();
        check("valid", evt_if.evt_valid, m_q.size() != 0);
        check("irq", irq, m_irq);
        check("pending", pending, m_pend);
        check("ovf", ovf_count, m_ovf);
        check("id", evt_if.evt_id, m_hid);
        check("ts", evt_if.evt_ts, m_hts);
    endtask

    // One clock: model follows the edge, outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic pulse(input logic [NA-1:0] bits);
        alarm_in = bits;
        step();
        step();
        alarm_in = '0;
        step();
        step();
    endtask

    int exp_ids[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 9};
    int got_ids[10];
    int k;

    initial begin
        evt_if.evt_ready = 1'b0;

        // Alarm held high across reset release produces nothing.
        alarm_in = 24'h000008;
        step();
        step();
        reset = 1'b0;
        step();
        step();
        step();
        check("held_valid", evt_if.evt_valid, 1'b0);
        check("held_pending", pending, 24'h0);
        alarm_in = '0;

        // Single pulse on bit 5 sampled at timestamp 10.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 100 && m_ts != 10; c++) step();
        alarm_in = 24'h000020;
        step();
        check("p5_pending", pending, 24'h000020);
        step();
        check("p5_valid", evt_if.evt_valid, 1'b1);
        check("p5_id", evt_if.evt_id, 5'd5);
        check("p5_ts", evt_if.evt_ts, 16'd11);
        check("p5_irq", irq, 1'b1);
        check("p5_clr", pending, 24'h0);
        alarm_in = '0;
        evt_if.evt_ready = 1'b1;
        step();
        evt_if.evt_ready = 1'b0;
        check("pop_valid", evt_if.evt_valid, 1'b0);
        check("pop_irq", irq, 1'b0);

        // Simultaneous rises drain in ascending order.
        alarm_in = 24'h100084;
        step();
        check("multi_p0", pending, 24'h100084);
        step();
        check("multi_p1", pending, 24'h100080);
        check("multi_id0", evt_if.evt_id, 5'd2);
        alarm_in = '0;
        step();
        check("multi_p2", pending, 24'h100000);
        step();
        check("multi_p3", pending, 24'h0);
        evt_if.evt_ready = 1'b1;
        for (int c = 0; c < 20 && evt_if.evt_valid; c++) step();
        check("multi_drained", evt_if.evt_valid, 1'b0);
        evt_if.evt_ready = 1'b0;

        // Fill the FIFO, back up two bits, coalesce one event.
        for (int b = 1; b <= 9; b++) pulse(24'h1 << b);
        pulse(24'h000001);
        pulse(24'h000001);
        check("full_pending", pending, 24'h000201);
        check("full_ovf", ovf_count, 8'd1);
        evt_if.evt_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && evt_if.evt_valid; c++) begin
            if (k < 10) got_ids[k] = evt_if.evt_id;
            k++;
            step();
        end
        evt_if.evt_ready = 1'b0;
        check("drain_count", k, 10);
        for (int i = 0; i < 10; i++) check("drain_id", got_ids[i], exp_ids[i]);
        check("drain_irq", irq, 1'b0);

        // Masked bit is ignored.
        alarm_mask = ~(24'h1 << 9);
        pulse(24'h000200);
        check("mask_pending", pending, 24'h0);
        check("mask_valid", evt_if.evt_valid, 1'b0);
        alarm_mask = '1;

        // Saturate the overflow counter via coalescing on bit 0.
        for (int p = 0; p < 9; p++) pulse(24'h000001);
        pulse(24'h000010);
        alarm_mask = ~(24'h1 << 4);
        step();
        check("mask_keeps", pending[4], 1'b1);
        alarm_mask = '1;
        for (int p = 0; p < 256; p++) pulse(24'h000001);
        check("ovf_sat", ovf_count, 8'd255);
        pulse(24'h000001);
        check("ovf_hold", ovf_count, 8'd255);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_clr", ovf_count, 8'd0);
        alarm_in = 24'h000001;
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        alarm_in = '0;
        step();
        check("ovf_clr_inc", ovf_count, 8'd1);

        // Reset mid-operation discards everything.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_valid", evt_if.evt_valid, 1'b0);
        check("rst_pending", pending, 24'h0);
        check("rst_ovf", ovf_count, 8'd0);
        check("rst_id", evt_if.evt_id, 5'd0);
        check("rst_ts", evt_if.evt_ts, 16'd0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            alarm_in = alarm_in ^ (24'($urandom) & 24'($urandom) & 24'($urandom));
            alarm_mask = ($urandom_range(0, 7) == 0) ? 24'($urandom) : '1;
            evt_if.evt_ready = 1'($urandom_range(0, 1));
            clr_ovf = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        clr_ovf = 1'b0;
        alarm_mask = '1;
        alarm_in = '0;
        evt_if.evt_ready = 1'b0;

        // Timestamp wrap across two consecutive pushes.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 70000 && m_ts != 16'hFFFE; c++) step();
        alarm_in = 24'h000003;
        step();
        step();
        check("wrap_ts0", evt_if.evt_ts, 16'hFFFF);
        check("wrap_id0", evt_if.evt_id, 5'd0);
        step();
        alarm_in = '0;
        evt_if.evt_ready = 1'b1;
        step();
        evt_if.evt_ready = 1'b0;
        check("wrap_ts1", evt_if.evt_ts, 16'h0000);
        check("wrap_id1", evt_if.evt_id, 5'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ats21_alarm_collector.md
# ats21_alarm_collector

Downstream consumer of the ATS21 `data[23:0]` alarm/timer "finished" vector. It detects the rising edge of each alarm bit; every ATS21 expiry is a 2-cycle pulse, so one pulse counts as one event. Each event is queued as an {alarm id, timestamp} record in a small FIFO and presented to the host on a valid/ready port. The block also drives an interrupt and counts coalesced (lost) events.

## Interface
Parameters:
- `NUM_ALARMS`, 24: width of the alarm vector; matches the ATS21 alarm count.
- `FIFO_DEPTH`, 8: event FIFO entries; must be a power of 2, at least 2.
- `TS_WIDTH`, 16: timestamp width; matches the ATS21 clock width.

Ports:
- `clk`, in, 1: single clock, same as ATS21 `clk`.
- `reset`, in, 1: synchronous, active-high.
- `alarm_in`, in, NUM_ALARMS: ATS21 `data` output.
- `alarm_mask`, in, NUM_ALARMS: 1 = bit enabled for capture.
- `evt_valid`, out, 1: FIFO head valid.
- `evt_ready`, in, 1: host accepts the head this cycle.
- `evt_id`, out, 5: alarm index of the head record.
- `evt_ts`, out, TS_WIDTH: timestamp of the head record.
- `irq`, out, 1: interrupt, registered.
- `pending`, out, NUM_ALARMS: detected events not yet queued.
- `ovf_count`, out, 8: saturating count of coalesced events.
- `clr_ovf`, in, 1: clears `ovf_count`.

## Operation
- `prev` register holds last cycle's `alarm_in`. `rise = alarm_in & ~prev & alarm_mask`.
- `pending[i]` is set on `rise[i]` and cleared when alarm i is pushed to the FIFO.
- Arbiter: each cycle, the lowest set index of `pending` is selected; at most one push per cycle.
- Push condition: `pending != 0` and (FIFO not full, or a pop occurs in the same cycle).
- Record pushed: {id = selected index, ts = timestamp counter value at the push edge}.
- Timestamp counter: TS_WIDTH bits, 0 at reset, +1 every cycle, wraps from all-ones to 0.
- Coalescing:
  - `rise[i]` while `pending[i]` is already 1 and not being pushed this cycle: `pending[i]` stays 1 and `ovf_count` increments.
  - `rise[i]` on the same cycle `pending[i]` is pushed: `pending[i]` stays set and no overflow is counted.
- `ovf_count` saturates at 255. `clr_ovf` zeroes it. If `clr_ovf` and an increment coincide, the result is 1.
- Pop occurs when `evt_valid & evt_ready`. The FIFO is show-ahead: `evt_id` and `evt_ts` always reflect the head.
- `irq` is registered; it equals (FIFO count != 0) after each edge.
- Mask:
  - A masked bit never sets `pending`.
  - Clearing a mask bit does not clear an existing `pending` bit.
- FIFO full: pending events wait; nothing is dropped except through coalescing.
- Empty FIFO: `evt_ready` is ignored. `evt_id`/`evt_ts` hold their last values (0 after reset).

## Timing
- Reset values:
  - `evt_valid`, `irq`, `pending`, `ovf_count`, `evt_id`, `evt_ts`, FIFO pointers, and timestamp counter are all 0.
  - `prev` loads `alarm_in` during reset, so an alarm bit already high at reset release produces no event.
- Latency, when the FIFO is empty and the bit has highest priority:
  - `alarm_in[i]` rises, first sampled at edge N: `pending[i]` = 1 after N.
  - Pushed at N+1: `evt_valid` and `irq` = 1 after N+1, `pending[i]` = 0.
  - `evt_ts` = timestamp counter value at N+1.
- k simultaneous rises: pushed on k consecutive edges in ascending index order.
- Pop at edge M with no concurrent push and count 1: `evt_valid` and `irq` = 0 after M.
- Pop and push at the same edge while full: count unchanged; the new record goes to the tail.
- Reset asserted mid-operation: all state returns to reset values at the next edge; queued records are discarded.

## Structure
- Shared package `ats21_pkg`:
  - `NUM_ALARMS`, `ALARM_ID_W` (5), `TS_WIDTH`.
  - `alarm_evt_t` packed struct {id, ts}.
  - Lowest-set-bit priority encode function (id plus found flag).
- Sub-module `ats21_evt_fifo`: synchronous show-ahead FIFO of `alarm_evt_t`.
  - Ports: push, pop, din, dout, full, empty, count.
  - Simultaneous push+pop is legal when full.
- Top level holds edge detect, pending, arbiter, timestamp counter, overflow counter, and irq.

## Test plan
- Reset with `alarm_in[3]` = 1, mask all-ones, then release → no event; `evt_valid` = 0, `pending` = 0.
- Mask all-ones, `evt_ready` = 0; 2-cycle pulse on bit 5 at cycle 10 → `pending` = 0x000020 after 10; after 11 `evt_valid` = 1, `evt_id` = 5, `evt_ts` = 11 (counter started at 0), `irq` = 1.
- Bits 2, 7, 20 rise together → records pushed on 3 consecutive cycles with ids 2, 7, 20; `pending` clears bit by bit.
- `FIFO_DEPTH` = 8, `evt_ready` = 0, 9 sequential single-bit pulses, then pulse bit 0 twice more → 8 records queued; bit 0 stays pending; `ovf_count` = 1. Raise `evt_ready` → all drain in order; the bit 0 record follows; `irq` falls after the last pop.
- Mask bit 9 = 0, pulse bit 9 → no event. Force `ovf_count` to 255 via repeated coalescing → it stays at 255. `clr_ovf` → 0.
- Counter near 0xFFFE, event pushed across the wrap → `evt_ts` = 0xFFFF then 0x0000 on consecutive records.
